// File: rtl/fetch_hazard_ctrl_if.sv
// Bundle of the fetch sequencer's pipeline-facing signals: hazard and cache
// status coming in, PC / pipeline-register control and perf counters going out.
interface fetch_hazard_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 32
);
    // Instruction cache
    logic                  ic_hit;
    logic                  ic_fill_done;
    logic                  ic_miss_req;
    // Decode-stage operands
    logic [4:0]            d_rs1;
    logic [4:0]            d_rs2;
    logic                  d_use_rs1;
    logic                  d_use_rs2;
    // Execute-stage status
    logic [4:0]            e_rd;
    logic                  e_mem_read;
    logic                  e_redirect;
    logic [DATA_WIDTH-1:0] e_target;
    // Data cache
    logic                  mem_stall;
    // PC and pipeline-register control
    logic                  pc_en;
    logic                  pc_sel;
    logic [DATA_WIDTH-1:0] pc_target;
    logic                  valid_f;
    logic                  fd_en;
    logic                  fd_flush_n;
    logic                  de_en;
    logic                  de_flush_n;
    // Performance counters
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    // Sequencer side
    modport master (
        input  ic_hit, ic_fill_done, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
               e_rd, e_mem_read, e_redirect, e_target, mem_stall,
        output ic_miss_req, pc_en, pc_sel, pc_target, valid_f, fd_en,
               fd_flush_n, de_en, de_flush_n, stall_cnt, flush_cnt
    );

    // Pipeline / cache side
    modport slave (
        output ic_hit, ic_fill_done, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
               e_rd, e_mem_read, e_redirect, e_target, mem_stall,
        input  ic_miss_req, pc_en, pc_sel, pc_target, valid_f, fd_en,
               fd_flush_n, de_en, de_flush_n, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// Fetch front-end sequencer. Controls PC update and the F/D and D/E pipeline
// registers while resolving icache misses, load-use hazards, execute redirects
// and dcache stalls. A redirect that arrives during an icache miss is latched
// and replayed once the fill completes.
module fetch_hazard_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_hazard_ctrl_if.master pipe_io
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MISS       = 2'd1,
        ST_MISS_REDIR = 2'd2,
        ST_REDIR      = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tgt_q, tgt_d;

    logic load_use;
    logic pc_en, pc_sel, valid_f, fd_en, fd_flush_n, de_en, de_flush_n, miss_req;
    logic redir_acc;   // a redirect is accepted this cycle
    logic stall_inc;   // PC held for a reason other than redirect

    // A load in execute whose destination is read by the instruction in decode.
    assign load_use = pipe_io.e_mem_read && (pipe_io.e_rd != 5'd0) &&
                      ((pipe_io.d_use_rs1 && (pipe_io.d_rs1 == pipe_io.e_rd)) ||
                       (pipe_io.d_use_rs2 && (pipe_io.d_rs2 == pipe_io.e_rd)));

    // Next-state and zero-latency control outputs; priority is
    // mem_stall > e_redirect > load_use > icache miss.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        pc_en      = 1'b0;
        pc_sel     = 1'b0;
        valid_f    = 1'b0;
        fd_en      = 1'b1;
        fd_flush_n = 1'b1;
        de_en      = 1'b1;
        de_flush_n = 1'b1;
        miss_req   = (state_q != ST_RUN);
        redir_acc  = 1'b0;

        if (pipe_io.mem_stall) begin
            // Whole pipe frozen; a completing fill still advances the miss FSM.
            fd_en = 1'b0;
            de_en = 1'b0;
            if (state_q == ST_REDIR) begin
                miss_req = 1'b0;
            end
            if (pipe_io.ic_fill_done) begin
                if (state_q == ST_MISS) begin
                    state_d = ST_RUN;
                end else if (state_q == ST_MISS_REDIR) begin
                    state_d = ST_REDIR;
                end
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pipe_io.e_redirect) begin
                        pc_sel     = 1'b1;
                        pc_en      = 1'b1;
                        fd_flush_n = 1'b0;
                        de_flush_n = 1'b0;
                        redir_acc  = 1'b1;
                    end else if (load_use) begin
                        fd_en      = 1'b0;
                        de_flush_n = 1'b0;
                    end else if (!pipe_io.ic_hit) begin
                        fd_flush_n = 1'b0;
                        miss_req   = 1'b1;
                        state_d    = ST_MISS;
                    end else begin
                        pc_en   = 1'b1;
                        valid_f = 1'b1;
                    end
                end
                ST_MISS: begin
                    fd_flush_n = 1'b0;
                    if (pipe_io.e_redirect && pipe_io.ic_fill_done) begin
                        // Fill finished, so the redirect can go straight to the PC.
                        pc_sel     = 1'b1;
                        pc_en      = 1'b1;
                        de_flush_n = 1'b0;
                        redir_acc  = 1'b1;
                        state_d    = ST_RUN;
                    end else if (pipe_io.e_redirect) begin
                        // Fill still outstanding: remember where to go afterwards.
                        de_flush_n = 1'b0;
                        tgt_d      = pipe_io.e_target;
                        redir_acc  = 1'b1;
                        state_d    = ST_MISS_REDIR;
                    end else begin
                        if (load_use) begin
                            fd_en      = 1'b0;
                            fd_flush_n = 1'b1;
                            de_flush_n = 1'b0;
                        end
                        // PC never moved, so the refetch after the fill hits.
                        if (pipe_io.ic_fill_done) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_MISS_REDIR: begin
                    fd_flush_n = 1'b0;
                    if (pipe_io.ic_fill_done) begin
                        pc_sel  = 1'b1;
                        pc_en   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin // ST_REDIR: replay the latched redirect
                    pc_sel     = 1'b1;
                    pc_en      = 1'b1;
                    fd_flush_n = 1'b0;
                    miss_req   = 1'b0;
                    state_d    = ST_RUN;
                end
            endcase
        end

        stall_inc = !pc_en && !redir_acc;

        // Reset holds the pipe quiet and drops any outstanding fill request.
        if (!rst_n) begin
            pc_en      = 1'b0;
            pc_sel     = 1'b0;
            valid_f    = 1'b0;
            fd_en      = 1'b0;
            fd_flush_n = 1'b0;
            de_en      = 1'b0;
            de_flush_n = 1'b0;
            miss_req   = 1'b0;
        end
    end

    // State and latched redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // A second redirect while one is already latched would be lost.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_MISS_REDIR)) begin
            assert (!pipe_io.e_redirect);
        end
    end

    // Perf counters: [0] stall cycles, [1] accepted redirects.
    logic [1:0] cnt_inc;
    assign cnt_inc = {redir_acc, stall_inc};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        // Saturating event counter; holds at all-ones instead of wrapping.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pipe_io.stall_cnt   = g_cnt[0].cnt_q;
    assign pipe_io.flush_cnt   = g_cnt[1].cnt_q;
    assign pipe_io.pc_en       = pc_en;
    assign pipe_io.pc_sel      = pc_sel;
    assign pipe_io.pc_target   = ((state_q == ST_MISS_REDIR) || (state_q == ST_REDIR)) ?
                                 tgt_q : pipe_io.e_target;
    assign pipe_io.valid_f     = valid_f;
    assign pipe_io.fd_en       = fd_en;
    assign pipe_io.fd_flush_n  = fd_flush_n;
    assign pipe_io.de_en       = de_en;
    assign pipe_io.de_flush_n  = de_flush_n;
    assign pipe_io.ic_miss_req = miss_req;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl. Each scenario drives one cycle at a time,
// pushes the expected control vector to a scoreboard queue and pops it when
// the outputs are sampled on the falling edge. Control vector bit order:
// {pc_en, pc_sel, valid_f, fd_en, fd_flush_n, de_en, de_flush_n, ic_miss_req}.
module tb_fetch_hazard_ctrl;

    localparam int DW    = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic          ic_hit, fill, mem_rd, use1, use2, redir, mstall;
        logic [4:0]    rs1, rs2, rd;
        logic [DW-1:0] tgt;
    } stim_t;

    typedef struct packed {
        logic [7:0]    ctl;
        logic [7:0]    mask;
        logic [DW-1:0] tgt;
        logic          chk_tgt;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   total;
    int   passed;
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;

    fetch_hazard_ctrl_if #(.DATA_WIDTH(DW), .CNT_W(CNT_W)) bus ();

    fetch_hazard_ctrl #(.DATA_WIDTH(DW), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pipe_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s        = '0;
        s.ic_hit = 1'b1;
        return s;
    endfunction

    function automatic exp_t mk(input logic [7:0] c, input logic [7:0] m,
                                input logic chk, input logic [DW-1:0] t);
        exp_t r;
        r.ctl     = c;
        r.mask    = m;
        r.chk_tgt = chk;
        r.tgt     = t;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] obs_ctl();
        return {bus.pc_en, bus.pc_sel, bus.valid_f, bus.fd_en,
                bus.fd_flush_n, bus.de_en, bus.de_flush_n, bus.ic_miss_req};
    endfunction

    task automatic apply(input stim_t s);
        bus.ic_hit       = s.ic_hit;
        bus.ic_fill_done = s.fill;
        bus.e_mem_read   = s.mem_rd;
        bus.d_use_rs1    = s.use1;
        bus.d_use_rs2    = s.use2;
        bus.e_redirect   = s.redir;
        bus.mem_stall    = s.mstall;
        bus.d_rs1        = s.rs1;
        bus.d_rs2        = s.rs2;
        bus.e_rd         = s.rd;
        bus.e_target     = s.tgt;
    endtask

    task automatic test_reset();
        stim_t s; exp_t e; logic [7:0] o;
        for (int i = 0; i < 3; i++) begin
            s     = idle();
            s.tgt = 32'h55;
            rst_n = (i == 2);
            e     = (i < 2) ? mk(8'h00, 8'hBF, 1'b0, '0) : mk(8'hBE, 8'hFF, 1'b1, 32'h55);
            apply(s); sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); o = obs_ctl(); total++;
            if ((o & e.mask) !== (e.ctl & e.mask))
                $display("FAIL reset[%0d] ctl got=%b want=%b", i, o & e.mask, e.ctl & e.mask);
            else passed++;
            if (e.chk_tgt) begin
                total++;
                if (bus.pc_target !== e.tgt)
                    $display("FAIL reset[%0d] pc_target got=%h want=%h", i, bus.pc_target, e.tgt);
                else passed++;
            end
            @(posedge clk); #1;
        end
        total++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {exp_stall, exp_flush})
            $display("FAIL reset counters got=%0d/%0d want=%0d/%0d", bus.stall_cnt, bus.flush_cnt, exp_stall, exp_flush);
        else passed++;
        $display("reset: done, stall_cnt=%0d flush_cnt=%0d", bus.stall_cnt, bus.flush_cnt);
    endtask

    task automatic test_miss();
        stim_t s; exp_t e; logic [7:0] o;
        for (int i = 0; i < 7; i++) begin
            s = idle();
            if (i < 6) begin
                s.ic_hit  = 1'b0;
                s.fill    = (i == 5);
                e         = mk(8'h17, 8'hFF, 1'b0, '0);
                exp_stall = sat(exp_stall);
            end else begin
                e = mk(8'hBE, 8'hFF, 1'b0, '0);
            end
            apply(s); sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); o = obs_ctl(); total++;
            if ((o & e.mask) !== (e.ctl & e.mask))
                $display("FAIL miss[%0d] ctl got=%b want=%b", i, o & e.mask, e.ctl & e.mask);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (bus.stall_cnt !== exp_stall)
            $display("FAIL miss stall_cnt got=%0d want=%0d", bus.stall_cnt, exp_stall);
        else passed++;
        $display("miss: done, stall_cnt=%0d", bus.stall_cnt);
    endtask

    task automatic test_load_use();
        stim_t s; exp_t e; logic [7:0] o;
        for (int i = 0; i < 5; i++) begin
            s = idle();
            e = mk(8'hBE, 8'hFF, 1'b0, '0);
            case (i)
                0: begin s.mem_rd = 1; s.rd = 5; s.rs1 = 5; s.use1 = 1; end
                1: begin s.mem_rd = 1; s.rd = 0; s.rs1 = 0; s.use1 = 1; end
                2: begin s.mem_rd = 1; s.rd = 7; s.rs1 = 7; s.rs2 = 7; s.use2 = 1; end
                3: begin s.mem_rd = 1; s.rd = 7; s.rs1 = 7; s.rs2 = 7; end
                default: begin s.rd = 7; s.rs1 = 7; s.use1 = 1; end
            endcase
            if (i == 0 || i == 2) begin
                e         = mk(8'h0C, 8'hDF, 1'b0, '0);
                exp_stall = sat(exp_stall);
            end
            apply(s); sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); o = obs_ctl(); total++;
            if ((o & e.mask) !== (e.ctl & e.mask))
                $display("FAIL load_use[%0d] ctl got=%b want=%b", i, o & e.mask, e.ctl & e.mask);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (bus.stall_cnt !== exp_stall)
            $display("FAIL load_use stall_cnt got=%0d want=%0d", bus.stall_cnt, exp_stall);
        else passed++;
        $display("load_use: done, stall_cnt=%0d", bus.stall_cnt);
    endtask

    task automatic test_miss_redirect();
        stim_t s; exp_t e; logic [7:0] o;
        for (int i = 0; i < 6; i++) begin
            s = idle();
            s.ic_hit = (i == 5);
            s.tgt    = 32'hDEAD;
            case (i)
                0: begin e = mk(8'h17, 8'hFF, 1'b0, '0); exp_stall = sat(exp_stall); end
                1: begin
                    s.redir = 1; s.tgt = 32'h100;
                    e = mk(8'h15, 8'hFF, 1'b1, 32'h100); exp_flush = sat(exp_flush);
                end
                2, 3: begin e = mk(8'h17, 8'hFF, 1'b1, 32'h100); exp_stall = sat(exp_stall); end
                4: begin s.fill = 1; e = mk(8'hD7, 8'hFF, 1'b1, 32'h100); end
                default: e = mk(8'hBE, 8'hFF, 1'b0, '0);
            endcase
            apply(s); sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); o = obs_ctl(); total++;
            if ((o & e.mask) !== (e.ctl & e.mask))
                $display("FAIL miss_redirect[%0d] ctl got=%b want=%b", i, o & e.mask, e.ctl & e.mask);
            else passed++;
            if (e.chk_tgt) begin
                total++;
                if (bus.pc_target !== e.tgt)
                    $display("FAIL miss_redirect[%0d] pc_target got=%h want=%h", i, bus.pc_target, e.tgt);
                else passed++;
            end
            @(posedge clk); #1;
        end
        total++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {exp_stall, exp_flush})
            $display("FAIL miss_redirect counters got=%0d/%0d want=%0d/%0d", bus.stall_cnt, bus.flush_cnt, exp_stall, exp_flush);
        else passed++;
        $display("miss_redirect: done, stall_cnt=%0d flush_cnt=%0d", bus.stall_cnt, bus.flush_cnt);
    endtask

    task automatic test_stall_redir();
        stim_t s; exp_t e; logic [7:0] o;
        for (int i = 0; i < 7; i++) begin
            s = idle();
            s.ic_hit = (i == 6);
            s.tgt    = 32'h333;
            case (i)
                0: begin e = mk(8'h17, 8'hFF, 1'b0, '0); exp_stall = sat(exp_stall); end
                1: begin
                    s.redir = 1; s.tgt = 32'h200;
                    e = mk(8'h15, 8'hFF, 1'b1, 32'h200); exp_flush = sat(exp_flush);
                end
                2: begin e = mk(8'h17, 8'hFF, 1'b1, 32'h200); exp_stall = sat(exp_stall); end
                3: begin
                    s.mstall = 1; s.fill = 1;
                    e = mk(8'h0B, 8'hFF, 1'b1, 32'h200); exp_stall = sat(exp_stall);
                end
                4: begin
                    s.mstall = 1;
                    e = mk(8'h0A, 8'hFE, 1'b1, 32'h200); exp_stall = sat(exp_stall);
                end
                5: e = mk(8'hD6, 8'hFF, 1'b1, 32'h200);
                default: e = mk(8'hBE, 8'hFF, 1'b0, '0);
            endcase
            apply(s); sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); o = obs_ctl(); total++;
            if ((o & e.mask) !== (e.ctl & e.mask))
                $display("FAIL stall_redir[%0d] ctl got=%b want=%b", i, o & e.mask, e.ctl & e.mask);
            else passed++;
            if (e.chk_tgt) begin
                total++;
                if (bus.pc_target !== e.tgt)
                    $display("FAIL stall_redir[%0d] pc_target got=%h want=%h", i, bus.pc_target, e.tgt);
                else passed++;
            end
            @(posedge clk); #1;
        end
        total++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {exp_stall, exp_flush})
            $display("FAIL stall_redir counters got=%0d/%0d want=%0d/%0d", bus.stall_cnt, bus.flush_cnt, exp_stall, exp_flush);
        else passed++;
        $display("stall_redir: done, stall_cnt=%0d flush_cnt=%0d", bus.stall_cnt, bus.flush_cnt);
    endtask

    task automatic test_redirect_priority();
        stim_t s; exp_t e; logic [7:0] o;
        for (int i = 0; i < 4; i++) begin
            s = idle();
            e = mk(8'hBE, 8'hFF, 1'b0, '0);
            if (i == 0) begin
                s.redir = 1; s.tgt = 32'h400; s.ic_hit = 0;
                s.mem_rd = 1; s.rd = 3; s.rs1 = 3; s.use1 = 1;
                e = mk(8'hD4, 8'hFF, 1'b1, 32'h400); exp_flush = sat(exp_flush);
            end else if (i == 2) begin
                s.mstall = 1; s.redir = 1; s.tgt = 32'h500; s.ic_hit = 0;
                e = mk(8'h0A, 8'hFF, 1'b0, '0); exp_stall = sat(exp_stall);
            end
            apply(s); sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); o = obs_ctl(); total++;
            if ((o & e.mask) !== (e.ctl & e.mask))
                $display("FAIL redirect_priority[%0d] ctl got=%b want=%b", i, o & e.mask, e.ctl & e.mask);
            else passed++;
            if (e.chk_tgt) begin
                total++;
                if (bus.pc_target !== e.tgt)
                    $display("FAIL redirect_priority[%0d] pc_target got=%h want=%h", i, bus.pc_target, e.tgt);
                else passed++;
            end
            @(posedge clk); #1;
        end
        total++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {exp_stall, exp_flush})
            $display("FAIL redirect_priority counters got=%0d/%0d want=%0d/%0d", bus.stall_cnt, bus.flush_cnt, exp_stall, exp_flush);
        else passed++;
        $display("redirect_priority: done, stall_cnt=%0d flush_cnt=%0d", bus.stall_cnt, bus.flush_cnt);
    endtask

    task automatic test_reset_mid_miss();
        stim_t s; exp_t e; logic [7:0] o;
        for (int i = 0; i < 4; i++) begin
            s = idle();
            s.ic_hit = (i == 3);
            rst_n    = (i != 2);
            if (i < 2) begin
                e = mk(8'h17, 8'hFF, 1'b0, '0); exp_stall = sat(exp_stall);
            end else if (i == 2) begin
                e = mk(8'h00, 8'hBF, 1'b0, '0); exp_stall = '0; exp_flush = '0;
            end else begin
                e = mk(8'hBE, 8'hFF, 1'b0, '0);
            end
            apply(s); sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); o = obs_ctl(); total++;
            if ((o & e.mask) !== (e.ctl & e.mask))
                $display("FAIL reset_mid_miss[%0d] ctl got=%b want=%b", i, o & e.mask, e.ctl & e.mask);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {exp_stall, exp_flush})
            $display("FAIL reset_mid_miss counters got=%0d/%0d want=%0d/%0d", bus.stall_cnt, bus.flush_cnt, exp_stall, exp_flush);
        else passed++;
        $display("reset_mid_miss: done, stall_cnt=%0d flush_cnt=%0d", bus.stall_cnt, bus.flush_cnt);
    endtask

    task automatic test_saturation();
        stim_t s; exp_t e; logic [7:0] o;
        for (int i = 0; i < 21; i++) begin
            s = idle();
            if (i < 20) begin
                s.mstall = 1;
                e = mk(8'h0A, 8'hFF, 1'b0, '0); exp_stall = sat(exp_stall);
            end else begin
                e = mk(8'hBE, 8'hFF, 1'b0, '0);
            end
            apply(s); sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front(); o = obs_ctl(); total++;
            if ((o & e.mask) !== (e.ctl & e.mask))
                $display("FAIL saturation[%0d] ctl got=%b want=%b", i, o & e.mask, e.ctl & e.mask);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {exp_stall, exp_flush})
            $display("FAIL saturation counters got=%0d/%0d want=%0d/%0d", bus.stall_cnt, bus.flush_cnt, exp_stall, exp_flush);
        else passed++;
        $display("saturation: done, stall_cnt=%0d", bus.stall_cnt);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        exp_stall = '0;
        exp_flush = '0;
        rst_n     = 1'b0;
        apply(idle());
        test_reset();
        test_miss();
        test_load_use();
        test_miss_redirect();
        test_stall_redir();
        test_redirect_priority();
        test_reset_mid_miss();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
